video_capture_rgb: RTL and testbench
====================================

VIDEO_CAPTURE_RGB -- requirements
Module: video_capture_rgb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning capture FIFO entries (power of two, 4..32).
REQ-002 SHALL have parameter VSYNC_POL, default 1'b1, meaning vsync_i level that is treated as active.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  sole clock; all logic on its rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- vsync_i  in  1  video vertical sync, as output by the blend stage.
- hsync_i  in  1  video horizontal sync; sampled only, not used for position.
- dv_de_i  in  1  display enable; high during visible pixels.
- rgb_i  in  12  blended pixel {R[11:8],G[7:4],B[3:0]}, qualified by dv_de_i.
- arm_i  in  1  one-cycle pulse that starts a capture request.
- abort_i  in  1  one-cycle pulse that cancels a capture in progress.
- start_x_i  in  11  visible-pixel column of the first captured pixel; sampled on arm.
- start_y_i  in  11  visible-line row of the first captured pixel; sampled on arm.
- count_i  in  6  number of pixels to capture (0..FIFO_DEPTH); sampled on arm.
- rd_data_o  out  12  FIFO head pixel.
- rd_valid_o  out  1  FIFO not empty.
- rd_ready_i  in  1  consumer pop; a pop occurs when rd_valid_o && rd_ready_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a capture completes or is aborted.
- overflow_o  out  1  sticky; a pixel was dropped because the FIFO was full.

Function
REQ-004 Column counter x SHALL increment on each cycle where dv_de_i=1, and SHALL clear to 0 on the cycle after dv_de_i falls (1->0).
REQ-005 Row counter y SHALL increment on each dv_de_i falling edge, and SHALL clear to 0 on the vsync_i inactive->active edge (polarity set by VSYNC_POL).
REQ-006 Both counters SHALL saturate at 2047 and SHALL NOT wrap.
REQ-007 The FSM SHALL have the states IDLE, WAIT_FRAME, SEEK, CAPTURE and DONE.
REQ-008 IDLE -> WAIT_FRAME on arm_i with count_i!=0; start_x_i, start_y_i and count_i SHALL be latched, and overflow_o SHALL be cleared.
REQ-009 IDLE -> DONE on arm_i with count_i==0; no pixels are captured.
REQ-010 arm_i in any state other than IDLE SHALL be ignored.
REQ-011 WAIT_FRAME -> SEEK on the next vsync active edge, so a capture never starts mid-frame.
REQ-012 SEEK -> CAPTURE on the cycle where dv_de_i=1, x==start_x and y==start_y; that cycle's rgb_i SHALL be the first captured pixel.
REQ-013 In CAPTURE, each cycle with dv_de_i=1 SHALL push rgb_i and decrement the remaining count.
REQ-014 CAPTURE -> DONE when the remaining count reaches 0.
REQ-015 CAPTURE -> DONE when dv_de_i=0; captures never span lines, and the short capture SHALL NOT be flagged.
REQ-016 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-017 abort_i in WAIT_FRAME, SEEK or CAPTURE SHALL go to DONE next cycle; FIFO contents are retained.
REQ-018 abort_i in IDLE or DONE SHALL be ignored.
REQ-019 abort_i and arm_i in the same cycle while in IDLE: arm wins.
REQ-020 FIFO SHALL be first-word-fall-through: a pixel pushed on cycle N appears on rd_data_o with rd_valid_o=1 at cycle N+1 if the FIFO was empty.
REQ-021 Push while full SHALL drop the pixel and set overflow_o.
REQ-022 Push while full in the same cycle as a pop SHALL be accepted, and overflow_o SHALL NOT be set.
REQ-023 Push and pop on the same cycle when empty: only the push takes effect.
REQ-024 A dropped pixel SHALL still decrement the remaining count.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit to distinguish full from empty.
REQ-026 The FIFO SHALL NOT be cleared by arm_i; the consumer drains it.

Reset
REQ-027 reset_n_i=0 SHALL give, on the next edge: FSM=IDLE; x=0; y=0; FIFO empty; rd_valid_o=0; rd_data_o=0; busy_o=0; done_o=0; overflow_o=0; latched parameters=0.
REQ-028 Reset mid-CAPTURE SHALL discard FIFO contents and SHALL NOT pulse done_o.

Verification
REQ-029 Arm with (x=5,y=2,count=4) on a 640-pixel frame with rgb_i=column index -> after the next vsync, FIFO holds 0x005,0x006,0x007,0x008; done_o pulses once; busy_o low after.
REQ-030 Arm with (x=638,y=0,count=8) -> 2 pixels captured (0x27E,0x27F); done_o pulses at line end; overflow_o=0.
REQ-031 Arm with count=20, FIFO_DEPTH=16, rd_ready_i=0 -> 16 entries held; overflow_o=1; done_o after 20 visible pixels.
REQ-032 Same as REQ-031 but rd_ready_i=1 throughout -> 20 pixels popped in order; overflow_o=0.
REQ-033 Arm, then abort_i during SEEK -> done_o the next cycle; FIFO empty; a second arm_i during busy is ignored.
REQ-034 reset_n_i low for 1 cycle mid-CAPTURE -> all outputs at their REQ-027 values; no done_o pulse.

Source files
------------

// File: rtl/video_capture_rgb.sv
// Captures a run of blended pixels at a programmed (x,y) frame position
// into a first-word-fall-through FIFO for a consumer to drain.
module video_capture_rgb #(
   parameter int   FIFO_DEPTH = 16,
   parameter logic VSYNC_POL  = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        vsync_i,
   input  logic        hsync_i,
   input  logic        dv_de_i,
   input  logic [11:0] rgb_i,
   input  logic        arm_i,
   input  logic        abort_i,
   input  logic [10:0] start_x_i,
   input  logic [10:0] start_y_i,
   input  logic [5:0]  count_i,
   output logic [11:0] rd_data_o,
   output logic        rd_valid_o,
   input  logic        rd_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        overflow_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, WAIT_FRAME, SEEK, CAPTURE, DONE} state_t;

   state_t        state, nxt;
   logic          de_q, vs_q, vs_act, vs_rise, de_fall;
   logic [10:0]   x, y, sx, sy;
   logic [5:0]    rem;
   logic          push, pop, wr_en, full, empty, arm_take;
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [11:0]   mem [FIFO_DEPTH];

   // hsync carries no position information here; it is only observed.
   logic unused_hsync;
   assign unused_hsync = hsync_i;

   assign vs_act   = (vsync_i == VSYNC_POL);
   assign vs_rise  = vs_act && !vs_q;
   assign de_fall  = de_q && !dv_de_i;
   assign arm_take = (state == IDLE) && arm_i && (count_i != '0);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && rd_ready_i;
   // A full FIFO still accepts a push when the same cycle pops its head.
   assign wr_en = push && (!full || pop);

   assign rd_valid_o = !empty;
   assign rd_data_o  = empty ? 12'h000 : mem[rd_ptr[AW-1:0]];
   assign busy_o     = (state != IDLE);
   assign done_o     = (state == DONE);

   always_comb begin
      nxt  = state;
      push = 1'b0;
      case (state)
         IDLE:       if (arm_i) nxt = (count_i != '0) ? WAIT_FRAME : DONE;
         WAIT_FRAME: if (abort_i) nxt = DONE;
                     else if (vs_rise) nxt = SEEK;
         SEEK: begin
            if (abort_i) nxt = DONE;
            else if (dv_de_i && x == sx && y == sy) begin
               push = 1'b1;
               nxt  = CAPTURE;
            end
         end
         CAPTURE: begin
            // A capture ends at the line end without being flagged as short.
            if (abort_i || !dv_de_i || rem == '0) nxt = DONE;
            else begin
               push = 1'b1;
               if (rem == 6'd1) nxt = DONE;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         state      <= IDLE;
         de_q       <= 1'b0;
         vs_q       <= 1'b0;
         x          <= '0;
         y          <= '0;
         sx         <= '0;
         sy         <= '0;
         rem        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_o <= 1'b0;
      end else begin
         state <= nxt;
         de_q  <= dv_de_i;
         vs_q  <= vs_act;

         if (dv_de_i) begin
            if (x != 11'h7FF) x <= x + 11'd1;
         end else if (de_q) begin
            x <= '0;
         end

         if (vs_rise)                      y <= '0;
         else if (de_fall && y != 11'h7FF) y <= y + 11'd1;

         // Dropped pixels still consume the remaining count.
         if (arm_take) begin
            sx  <= start_x_i;
            sy  <= start_y_i;
            rem <= count_i;
         end else if (push) begin
            rem <= rem - 6'd1;
         end

         if (arm_take)                  overflow_o <= 1'b0;
         else if (push && full && !pop) overflow_o <= 1'b1;

         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= rgb_i;
   end

endmodule

// File: tb/tb_video_capture_rgb.sv
// Bench for video_capture_rgb: table of directed captures, hand-written
// abort/reset sequences and randomized frames against a pixel-list model.
module tb_video_capture_rgb;
   logic        clk = 1'b0, reset_n_i = 1'b0;
   logic        vsync_i = 1'b0, hsync_i = 1'b0, dv_de_i = 1'b0;
   logic [11:0] rgb_i = '0;
   logic        arm_i = 1'b0, abort_i = 1'b0, rd_ready_i = 1'b0;
   logic [10:0] start_x_i = '0, start_y_i = '0;
   logic [5:0]  count_i = '0;
   logic [11:0] rd_data_o;
   logic        rd_valid_o, busy_o, done_o, overflow_o;

   video_capture_rgb #(.FIFO_DEPTH(16), .VSYNC_POL(1'b1)) dut (
      .clk(clk), .reset_n_i(reset_n_i), .vsync_i(vsync_i), .hsync_i(hsync_i),
      .dv_de_i(dv_de_i), .rgb_i(rgb_i), .arm_i(arm_i), .abort_i(abort_i),
      .start_x_i(start_x_i), .start_y_i(start_y_i), .count_i(count_i),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
      .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_pass = 0;
   int          ready_mode = 0;     // 0: hold off, 1: always ready, 2: random
   int          cur_col = -1;       // visible column being presented, -1 in blanking
   logic [11:0] popq[$];
   int          done_cnt = 0, done_col = -2;
   logic [11:0] pix [0:3][0:23];

   // Observe pops and done pulses half a cycle before the edge that acts on them.
   always @(negedge clk) begin
      if (done_o) begin
         done_cnt = done_cnt + 1;
         done_col = cur_col;
      end
      if (reset_n_i && rd_valid_o && rd_ready_i) popq.push_back(rd_data_o);
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       rd_ready_i = 1'b0;
         1:       rd_ready_i = 1'b1;
         default: rd_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask

   task automatic cyc(input logic vs, input logic de, input logic [11:0] px, input int col);
      @(posedge clk); #1;
      vsync_i = vs;
      dv_de_i = de;
      hsync_i = ~de;
      rgb_i   = de ? px : 12'h000;
      cur_col = de ? col : -1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 12'h000, -1);
   endtask

   task automatic pulse_arm(input int sx, input int sy, input int cnt);
      @(posedge clk); #1;
      arm_i = 1'b1; start_x_i = 11'(sx); start_y_i = 11'(sy); count_i = 6'(cnt);
      @(posedge clk); #1;
      arm_i = 1'b0;
   endtask

   task automatic drive_frame(input int w, input int h, input bit rnd);
      repeat (3) cyc(1'b1, 1'b0, 12'h000, -1);
      idle(3);
      for (int ln = 0; ln < h; ln++) begin
         for (int c = 0; c < w; c++) cyc(1'b0, 1'b1, rnd ? pix[ln][c] : 12'(c), c);
         idle(8);
      end
      idle(4);
   endtask

   typedef struct {
      int sx, sy, cnt, mode;
      int n_exp, first_exp, ovf_exp, done_col_exp;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int base, d0, n;
      // Directed captures on a 640-wide frame with rgb = column index.
      tbl[0] = '{sx: 5,   sy: 2, cnt: 4,  mode: 0, n_exp: 4,  first_exp: 5,   ovf_exp: 0, done_col_exp: 9};
      tbl[1] = '{sx: 638, sy: 0, cnt: 8,  mode: 1, n_exp: 2,  first_exp: 638, ovf_exp: 0, done_col_exp: -1};
      tbl[2] = '{sx: 0,   sy: 0, cnt: 20, mode: 0, n_exp: 16, first_exp: 0,   ovf_exp: 1, done_col_exp: 20};
      tbl[3] = '{sx: 0,   sy: 0, cnt: 20, mode: 1, n_exp: 20, first_exp: 0,   ovf_exp: 0, done_col_exp: 20};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset rd_valid", int'(rd_valid_o), 0);
      chk("reset rd_data",  int'(rd_data_o),  0);
      chk("reset busy",     int'(busy_o),     0);
      chk("reset done",     int'(done_o),     0);
      chk("reset overflow", int'(overflow_o), 0);
      @(posedge clk); #1;
      reset_n_i = 1'b1;
      idle(4);

      foreach (tbl[i]) begin
         ready_mode = tbl[i].mode;
         base = popq.size();
         d0   = done_cnt;
         pulse_arm(tbl[i].sx, tbl[i].sy, tbl[i].cnt);
         drive_frame(640, 3, 1'b0);
         @(negedge clk);
         chk($sformatf("vec%0d busy after", i), int'(busy_o), 0);
         chk($sformatf("vec%0d overflow", i), int'(overflow_o), tbl[i].ovf_exp);
         chk($sformatf("vec%0d done pulses", i), done_cnt - d0, 1);
         chk($sformatf("vec%0d done column", i), done_col, tbl[i].done_col_exp);
         ready_mode = 1;
         idle(24);
         chk($sformatf("vec%0d popped count", i), popq.size() - base, tbl[i].n_exp);
         for (int k = 0; k < tbl[i].n_exp; k++)
            chk($sformatf("vec%0d data[%0d]", i, k),
                (base + k < popq.size()) ? int'(popq[base + k]) : -1, tbl[i].first_exp + k);
      end

      // Abort while seeking; a second arm while busy must not act.
      ready_mode = 1;
      base = popq.size();
      d0   = done_cnt;
      pulse_arm(3, 1, 5);
      pulse_arm(0, 0, 0);
      @(negedge clk);
      chk("abort: ignored arm gives no done", done_cnt - d0, 0);
      chk("abort: busy while waiting", int'(busy_o), 1);
      repeat (2) cyc(1'b1, 1'b0, 12'h000, -1);
      idle(2);
      @(posedge clk); #1;
      abort_i = 1'b1;
      @(negedge clk);
      chk("abort: no done yet", int'(done_o), 0);
      @(posedge clk); #1;
      abort_i = 1'b0;
      @(negedge clk);
      chk("abort: done next cycle", int'(done_o), 1);
      chk("abort: fifo empty", int'(rd_valid_o), 0);
      for (int ln = 0; ln < 2; ln++) begin
         for (int c = 0; c < 24; c++) cyc(1'b0, 1'b1, 12'(c), c);
         idle(8);
      end
      @(negedge clk);
      chk("abort: busy low", int'(busy_o), 0);
      chk("abort: one done", done_cnt - d0, 1);
      chk("abort: nothing captured", popq.size() - base, 0);

      // One-cycle reset in the middle of a capture.
      ready_mode = 0;
      base = popq.size();
      d0   = done_cnt;
      pulse_arm(0, 0, 10);
      repeat (2) cyc(1'b1, 1'b0, 12'h000, -1);
      idle(2);
      for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1, 12'(c), c);
      cyc(1'b0, 1'b1, 12'd5, 5);
      reset_n_i = 1'b0;
      cyc(1'b0, 1'b1, 12'd6, 6);
      reset_n_i = 1'b1;
      @(negedge clk);
      chk("rst mid: rd_valid", int'(rd_valid_o), 0);
      chk("rst mid: rd_data",  int'(rd_data_o),  0);
      chk("rst mid: busy",     int'(busy_o),     0);
      chk("rst mid: done",     int'(done_o),     0);
      chk("rst mid: overflow", int'(overflow_o), 0);
      ready_mode = 1;
      for (int c = 7; c < 24; c++) cyc(1'b0, 1'b1, 12'(c), c);
      idle(10);
      chk("rst mid: no done pulse", done_cnt - d0, 0);
      chk("rst mid: nothing popped", popq.size() - base, 0);

      // Randomized frames: expected pixels are the run on row sy from column sx,
      // truncated at the line end or after cnt pixels.
      for (int it = 0; it < 20; it++) begin
         int sx, sy, cnt;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 24; c++) pix[r][c] = 12'($urandom);
         sx  = $urandom_range(0, 23);
         sy  = $urandom_range(0, 3);
         cnt = $urandom_range(1, 16);
         n   = (cnt < 24 - sx) ? cnt : 24 - sx;
         ready_mode = 2;
         base = popq.size();
         d0   = done_cnt;
         pulse_arm(sx, sy, cnt);
         drive_frame(24, 4, 1'b1);
         ready_mode = 1;
         idle(24);
         @(negedge clk);
         chk($sformatf("rnd%0d overflow", it), int'(overflow_o), 0);
         chk($sformatf("rnd%0d done pulses", it), done_cnt - d0, 1);
         chk($sformatf("rnd%0d popped count", it), popq.size() - base, n);
         for (int k = 0; k < n; k++)
            chk($sformatf("rnd%0d data[%0d]", it, k),
                (base + k < popq.size()) ? int'(popq[base + k]) : -1, int'(pix[sy][sx + k]));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
